// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_draw_scheduler
//  Purpose  : Round-robin arbiter sharing one VGA plot port among N sprite
//             requesters. Each grant erases the sprite's previous 5x5
//             footprint with BG_COLOUR, plots the new 5x5 bitmap pixel by
//             pixel, then pulses a one-hot ack to the winner.
//  Options  : SPRITE_SKIP_UNCHANGED_EN - when defined, a grant whose
//             latched position equals the sprite's last drawn position skips
//             erase and draw and goes straight to ack.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_draw_scheduler #(
  parameter int         N         = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [8*N-1:0]  x_in,
  input  logic [7*N-1:0]  y_in,
  input  logic [25*N-1:0] shape_in,
  input  logic [3*N-1:0]  colour_in,
  output logic [N-1:0]    ack,
  output logic            busy,
  output logic [7:0]      vga_x,
  output logic [6:0]      vga_y,
  output logic [2:0]      vga_colour,
  output logic            vga_plot
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // --------------------------------------------------------------------------
  // Per-requester views of the packed input buses
  // --------------------------------------------------------------------------
  logic [7:0]  w_x_arr      [N];
  logic [6:0]  w_y_arr      [N];
  logic [24:0] w_shape_arr  [N];
  logic [2:0]  w_colour_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_x_arr[gi]      = x_in[8*gi +: 8];
    assign w_y_arr[gi]      = y_in[7*gi +: 7];
    assign w_shape_arr[gi]  = shape_in[25*gi +: 25];
    assign w_colour_arr[gi] = colour_in[3*gi +: 3];
  end

  // --------------------------------------------------------------------------
  // State and working registers
  // --------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [24:0]   shape_q, shape_d;
  logic [2:0]    colour_q, colour_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    row_q, row_d;

  // Per-sprite memory of the last drawn footprint
  logic [7:0]    prev_x_q [N];
  logic [6:0]    prev_y_q [N];
  logic [N-1:0]  prev_valid_q;
  logic [GW-1:0] last_grant_q;

  // Registered plot port and ack
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_colour_q, vga_colour_d;
  logic          vga_plot_q, vga_plot_d;
  logic [N-1:0]  ack_q, ack_d;

  // Arbitration results
  int            w_cand;
  logic          w_win_found;
  logic [GW-1:0] w_win_idx;
  logic          w_same_pos;
  logic          w_last_px;

  assign w_last_px = (col_q == 3'd4) && (row_q == 3'd4);

  // Round-robin search: first pending request after the last winner, wrapping
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = int'(last_grant_q) + k;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      if (!w_win_found && req[GW'(w_cand)]) begin
        w_win_found = 1'b1;
        w_win_idx   = GW'(w_cand);
      end
    end
  end

`ifdef SPRITE_SKIP_UNCHANGED_EN
  // A re-request at the already drawn position needs no pixel traffic
  assign w_same_pos = prev_valid_q[w_win_idx] &&
                      (w_x_arr[w_win_idx] == prev_x_q[w_win_idx]) &&
                      (w_y_arr[w_win_idx] == prev_y_q[w_win_idx]);
`else
  assign w_same_pos = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: erase only when the sprite has a footprint on screen
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_win_found) begin
          if (w_same_pos) begin
            state_d = S_ACK;
          end else if (prev_valid_q[w_win_idx]) begin
            state_d = S_ERASE;
          end else begin
            state_d = S_DRAW;
          end
        end
      end
      S_ERASE: if (w_last_px) state_d = S_DRAW;
      S_DRAW:  if (w_last_px) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: pixel address/colour for the current step, ack in S_ACK
  always_comb begin
    vga_x_d      = 8'd0;
    vga_y_d      = 7'd0;
    vga_colour_d = 3'd0;
    vga_plot_d   = 1'b0;
    ack_d        = '0;
    case (state_q)
      S_ERASE: begin
        vga_x_d      = prev_x_q[grant_q] + {5'd0, col_q};
        vga_y_d      = prev_y_q[grant_q] + {4'd0, row_q};
        vga_colour_d = BG_COLOUR;
        vga_plot_d   = 1'b1;
      end
      S_DRAW: begin
        vga_x_d      = x_q + {5'd0, col_q};
        vga_y_d      = y_q + {4'd0, row_q};
        vga_colour_d = colour_q;
        // Bitmap is shifted left once per pixel, so bit 24 is always current
        vga_plot_d   = shape_q[24];
      end
      S_ACK: begin
        ack_d = {{(N-1){1'b0}}, 1'b1} << grant_q;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Working register next values: latch winner, then walk the 5x5 raster
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    shape_d  = shape_q;
    colour_d = colour_q;
    grant_d  = grant_q;
    col_d    = col_q;
    row_d    = row_q;
    case (state_q)
      S_IDLE: begin
        if (w_win_found) begin
          x_d      = w_x_arr[w_win_idx];
          y_d      = w_y_arr[w_win_idx];
          shape_d  = w_shape_arr[w_win_idx];
          colour_d = w_colour_arr[w_win_idx];
          grant_d  = w_win_idx;
          col_d    = 3'd0;
          row_d    = 3'd0;
        end
      end
      S_ERASE, S_DRAW: begin
        if (col_q == 3'd4) begin
          col_d = 3'd0;
          row_d = w_last_px ? 3'd0 : row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
        if (state_q == S_DRAW) begin
          shape_d = {shape_q[23:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Working registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      shape_q  <= 25'd0;
      colour_q <= 3'd0;
      grant_q  <= '0;
      col_q    <= 3'd0;
      row_q    <= 3'd0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      shape_q  <= shape_d;
      colour_q <= colour_d;
      grant_q  <= grant_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  // Footprint memory and arbitration pointer, committed on completion only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_valid_q <= '0;
      last_grant_q <= LAST_IDX;
      for (int i = 0; i < N; i++) begin
        prev_x_q[i] <= 8'd0;
        prev_y_q[i] <= 7'd0;
      end
    end else if (state_q == S_ACK) begin
      prev_x_q[grant_q]     <= x_q;
      prev_y_q[grant_q]     <= y_q;
      prev_valid_q[grant_q] <= 1'b1;
      last_grant_q          <= grant_q;
    end
  end

  // Registered plot port and ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      ack_q        <= '0;
    end else begin
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      ack_q        <= ack_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign ack        = ack_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Shares the single VGA plot port among N sprite requesters: pacman and the ghosts.
- Each requester presents its 5x5 shape bitmap, position and colour, and raises req.
- The scheduler grants requesters round-robin and erases the sprite's previous 5x5 footprint with the background colour.
- It then plots the new sprite pixel by pixel and pulses ack to the winner.
- Sits between the sprite controllers/movement handlers and the VGA adapter.

Parameters:
- N, 4, number of requesters (2..8).
- BG_COLOUR, 3'b000, colour used for erase.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  draw request per sprite; level, held until ack.
- x_in  input  8*N  sprite i top-left x at [8i+7:8i].
- y_in  input  7*N  sprite i top-left y at [7i+6:7i].
- shape_in  input  25*N  sprite i bitmap at [25i+24:25i].
- colour_in  input  3*N  sprite i colour at [3i+2:3i].
- ack  output  N  one-cycle completion pulse, one-hot.
- busy  output  1  high whenever state != IDLE.
- vga_x  output  8  plot x.
- vga_y  output  7  plot y.
- vga_colour  output  3  plot colour.
- vga_plot  output  1  plot enable.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; ack, busy, vga_x, vga_y, vga_colour and vga_plot all 0.
  - prev_valid[N-1:0]=0; last_grant=N-1, so requester 0 wins first.
- Shape mapping: pixel index p=0..24 uses bit [24-p]; col=p%5, row=p/5. Implement as col/row counters, no divider.
- Coordinates: vga_x = x + col (8-bit wrap-around); vga_y = y + row (7-bit wrap-around). No clipping.
- All vga_* outputs are registered.
- FSM states: IDLE, ERASE, DRAW, ACK.
- IDLE:
  - If any req bit is set, select the winner g as the first set bit scanning (last_grant+1) mod N upward, wrapping.
  - Latch x, y, shape and colour of g into working registers.
  - Go to ERASE if prev_valid[g], else DRAW. Reset col and row to 0.
  - Otherwise remain in IDLE with vga_plot=0.
- ERASE:
  - 25 cycles, one pixel per cycle at prev_x[g]+col, prev_y[g]+row.
  - vga_plot=1 for every pixel, vga_colour=BG_COLOUR.
  - After pixel 24, go to DRAW with counters cleared.
- DRAW:
  - 25 cycles at latched x+col, y+row.
  - vga_plot = shape bit, vga_colour = latched colour.
  - Zero bits produce vga_plot=0 but still consume a cycle.
  - After pixel 24, go to ACK.
- ACK:
  - ack[g]=1 for exactly one cycle.
  - prev_x[g], prev_y[g] = latched x, y; prev_valid[g]=1; last_grant=g.
  - Next state is IDLE.
- Latency from the req sample edge:
  - First plot appears the next cycle.
  - ack is asserted 51 cycles after grant with erase, 26 without.
  - At least one IDLE cycle separates consecutive grants.
- Input changes after grant are ignored; the latched copy is drawn.
- req dropped mid-operation: the operation still completes and ack still pulses.
- req held after ack: treated as a new request, subject to round-robin.
- Simultaneous requests: exactly one grant. No requester waits more than N-1 other grants.
- Reset mid-operation: aborts immediately. No ack. Previous positions are forgotten.

Optional Feature:
- Macro: SPRITE_SKIP_UNCHANGED_EN.
- Defined: if prev_valid[g] and the latched x,y equal prev_x[g], prev_y[g], IDLE goes directly to ACK.
  - No plots occur and ack is asserted 1 cycle after grant.
  - Shape and colour changes at an unchanged position are therefore not redrawn.
- Undefined: every grant performs the full erase/draw sequence.

Test Plan:
- First draw:
  - Stimulus: after reset, req=4'b0001, x0=10, y0=20, shape0=25'h1FFFFFF, colour0=3'b110.
  - Response: 25 plots at x 10..14, y 20..24, colour 110; ack[0] 26 cycles after grant; no erase plots.
- Move:
  - Stimulus: then req[0] again with x0=11.
  - Response: 25 erase plots at x 10..14 with colour 000, followed by 25 draw plots at x 11..15; ack 51 cycles after grant.
- Shape masking:
  - Stimulus: shape=25'b1111110101101011111110101 at x=0, y=0.
  - Response: pixel (1,1) has plot=0; pixel (0,0) has plot=1; exactly 19 plot pulses.
- Round-robin:
  - Stimulus: req=4'b1111 held continuously.
  - Response: grant order is 0,1,2,3,0; each ack is one-hot.
- Wrap:
  - Stimulus: x=254, y=126.
  - Response: plotted x values are 254,255,0,1,2 and y values are 126,127,0,1,2.
- Reset mid-DRAW:
  - Stimulus: assert reset in cycle 10 of DRAW.
  - Response: vga_plot=0 and busy=0 immediately, no ack; the next grant of the same sprite has no erase phase.
  - With SPRITE_SKIP_UNCHANGED_EN, a same-position re-request gives ack 1 cycle after grant with zero plots.
